// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//
// Serial bit-pattern transmitter. A parallel pattern of programmable length
// is latched on start and shifted out MSB-first, one bit per clock, repeated
// `reps` times (0 = forever) with `gap` idle cycles between repetitions.
// It is the transmit-side counterpart of the serial sequence detector and
// drives that block's `seq` input in loopback and self-test setups.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   start      begin a transfer (accepted only in IDLE)
//   pattern    bits to send, active field pattern[len-1:0]
//   len        bits per repetition, valid range 1..MAX_LEN
//   reps       repetition count, 0 = continuous until abort
//   gap        idle cycles between repetitions
//   abort      terminate the transfer at the next edge
//   seq        serial data bit (registered)
//   seq_valid  high while seq carries a pattern bit (registered)
//   busy       high in SEND and GAP (registered)
//   done       one-cycle pulse after the last bit of the last repetition
// ---------------------------------------------------------------------------
module sequence_generator #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               seq,
    output logic               seq_valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gapLen_q, gapLen_d;
    logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               seq_q, seq_d;
    logic               seqValid_q, seqValid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               lenOk;
    logic [IDX_W-1:0]   startIdx;
    logic [IDX_W-1:0]   reloadIdx;
    logic [IDX_W-1:0]   nextIdx;

    // Index helpers: startIdx comes from the live inputs (used only on the
    // accepting edge), reloadIdx from the latched length so that input
    // changes mid-transfer cannot disturb later repetitions.
    assign lenOk     = (len != '0) && (len <= MAX_LEN_L);
    assign startIdx  = IDX_W'(len - LEN_W'(1));
    assign reloadIdx = IDX_W'(len_q - LEN_W'(1));
    assign nextIdx   = idx_q - IDX_W'(1);

    // Next-state and registered-output logic. Every output is computed here
    // for the cycle after the edge, so the outputs all come straight from
    // flops. Outputs default to 0, which is the idle/gap/abort value; each
    // branch raises only what it needs.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        rep_d      = rep_q;
        gapLen_d   = gapLen_q;
        gapCnt_d   = gapCnt_q;
        idx_d      = idx_q;
        seq_d      = 1'b0;
        seqValid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // abort outranks start; an out-of-range len is ignored
                if (!abort && start && lenOk) begin
                    pat_d      = pattern;
                    len_d      = len;
                    rep_d      = reps;
                    gapLen_d   = gap;
                    idx_d      = startIdx;
                    seq_d      = pattern[startIdx];
                    seqValid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end

            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d      = nextIdx;
                    seq_d      = pat_q[nextIdx];
                    seqValid_d = 1'b1;
                    busy_d     = 1'b1;
                end else if (rep_q == CNT_W'(1)) begin
                    // bit 0 of the final repetition is on the line now
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    // a zero count means run forever, so never decrement it
                    if (rep_q != '0) begin
                        rep_d = rep_q - CNT_W'(1);
                    end
                    if (gapLen_q != '0) begin
                        state_d  = GAP;
                        gapCnt_d = gapLen_q;
                        busy_d   = 1'b1;
                    end else begin
                        idx_d      = reloadIdx;
                        seq_d      = pat_q[reloadIdx];
                        seqValid_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end

            GAP: begin
                // gapCnt holds the gap cycles still to show, including this one
                if (abort) begin
                    state_d = IDLE;
                end else if (gapCnt_q == GAP_W'(1)) begin
                    state_d    = SEND;
                    idx_d      = reloadIdx;
                    seq_d      = pat_q[reloadIdx];
                    seqValid_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                    busy_d   = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched transfer parameters, counters and output flops. Reset
    // clears everything, so a reset mid-transfer ends it with no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            gapLen_q   <= '0;
            gapCnt_q   <= '0;
            idx_q      <= '0;
            seq_q      <= 1'b0;
            seqValid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            rep_q      <= rep_d;
            gapLen_q   <= gapLen_d;
            gapCnt_q   <= gapCnt_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            seqValid_q <= seqValid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seq       = seq_q;
    assign seq_valid = seqValid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
//
// Self-checking bench for sequence_generator. Outputs are compared as the
// nibble {seq, seq_valid, busy, done} on the falling edge, one comparison per
// cycle. A table of single-shot transfers is run first, followed by
// hand-written sequences for continuous mode, abort, start-while-busy,
// abort/start collision and asynchronous reset with detector loopback.
// ---------------------------------------------------------------------------
module tb_sequence_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       abort;
    logic       seq;
    logic       seq_valid;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    sequence_generator #(
        .MAX_LEN(8),
        .LEN_W  (4),
        .CNT_W  (4),
        .GAP_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .reps     (reps),
        .gap      (gap),
        .abort    (abort),
        .seq      (seq),
        .seq_valid(seq_valid),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One transfer per record; bit [15-c] of each mask is the expected
    // value in cycle c after the start edge.
    typedef struct {
        string       name;
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic [3:0]  reps;
        logic [3:0]  gap;
        int          cycles;
        logic [15:0] expSeq;
        logic [15:0] expValid;
        logic [15:0] expBusy;
        logic [15:0] expDone;
    } vec_t;

    vec_t vecs[9];

    // Compare the output nibble against the bench's expected value.
    task automatic checkOutput(input string name, input logic [3:0] expected);
        logic [3:0] actual;
        actual = {seq, seq_valid, busy, done};
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: seq/valid/busy/done got %b expected %b at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Present a start request at a falling edge, let the rising edge sample
    // it, then scramble the data inputs so the latched copy is exercised.
    // Returns at the falling edge of the first cycle after the start edge.
    task automatic applyStimulus(input logic [7:0] p, input logic [3:0] l,
                                 input logic [3:0] r, input logic [3:0] g);
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        pattern = ~p;
        len     = 4'd2;
        reps    = 4'd7;
        gap     = 4'd5;
    endtask

    logic [7:0] contPat;
    logic [3:0] detShift;
    logic [3:0] expNib;
    int         pos;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;

        //                 name        pat    len  reps gap cyc  seq       valid     busy      done
        vecs[0] = '{"len4_rep1",  8'h0D, 4'd4, 4'd1, 4'd0, 6,  16'hD000, 16'hF000, 16'hF000, 16'h0800};
        vecs[1] = '{"len3_rep2g2",8'h05, 4'd3, 4'd2, 4'd2, 10, 16'hA500, 16'hE700, 16'hFF00, 16'h0080};
        vecs[2] = '{"len2_rep3",  8'h02, 4'd2, 4'd3, 4'd0, 8,  16'hA800, 16'hFC00, 16'hFC00, 16'h0200};
        vecs[3] = '{"len1_rep3",  8'h01, 4'd1, 4'd3, 4'd0, 5,  16'hE000, 16'hE000, 16'hE000, 16'h1000};
        vecs[4] = '{"len8_A5",    8'hA5, 4'd8, 4'd1, 4'd0, 10, 16'hA500, 16'hFF00, 16'hFF00, 16'h0080};
        vecs[5] = '{"len3_maskF2",8'hF2, 4'd3, 4'd1, 4'd0, 5,  16'h4000, 16'hE000, 16'hE000, 16'h1000};
        vecs[6] = '{"len0_ignore",8'hFF, 4'd0, 4'd1, 4'd0, 3,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[7] = '{"len9_ignore",8'hFF, 4'd9, 4'd1, 4'd0, 3,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{"len1_gap1",  8'h00, 4'd1, 4'd2, 4'd1, 5,  16'h0000, 16'hA000, 16'hE000, 16'h1000};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset", 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterReset", 4'b0000);

        // Abort in IDLE must not disturb anything
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortIdle", 4'b0000);

        // Table-driven single transfers
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].pattern, vecs[v].len, vecs[v].reps, vecs[v].gap);
            for (int c = 0; c < vecs[v].cycles; c++) begin
                if (c > 0) @(negedge clk);
                expNib = {vecs[v].expSeq[15-c], vecs[v].expValid[15-c],
                          vecs[v].expBusy[15-c], vecs[v].expDone[15-c]};
                checkOutput($sformatf("%s_c%0d", vecs[v].name, c + 1), expNib);
            end
        end

        // Continuous mode: 10110001 plus one gap cycle, repeated; a second
        // start while busy is ignored, then abort lands mid-byte.
        contPat = 8'hB1;
        applyStimulus(contPat, 4'd8, 4'd0, 4'd1);
        for (int n = 0; n < 31; n++) begin
            if (n > 0) @(negedge clk);
            pos = n % 9;
            if (pos < 8) expNib = {contPat[7-pos], 1'b1, 1'b1, 1'b0};
            else         expNib = 4'b0010;
            checkOutput($sformatf("cont_c%0d", n + 1), expNib);
            if (n == 4) begin
                pattern = 8'h0F;
                len     = 4'd2;
                reps    = 4'd1;
                start   = 1'b1;
            end
            if (n == 5) start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortSend", 4'b0000);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput($sformatf("abortSendNoDone_%0d", n), 4'b0000);
        end

        // Abort during the gap
        applyStimulus(8'h05, 4'd3, 4'd2, 4'd2);
        checkOutput("gapAbort_c1", 4'b1110);
        @(negedge clk);
        checkOutput("gapAbort_c2", 4'b0110);
        @(negedge clk);
        checkOutput("gapAbort_c3", 4'b1110);
        @(negedge clk);
        checkOutput("gapAbort_c4", 4'b0010);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortGap", 4'b0000);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput($sformatf("abortGapQuiet_%0d", n), 4'b0000);
        end

        // abort and start together in IDLE: abort wins
        pattern = 8'h0D;
        len     = 4'd4;
        reps    = 4'd1;
        gap     = 4'd0;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checkOutput($sformatf("abortStart_%0d", n), 4'b0000);
            @(negedge clk);
        end

        // Asynchronous reset between edges during SEND
        applyStimulus(8'h0D, 4'd4, 4'd1, 4'd0);
        checkOutput("preReset_c1", 4'b1110);
        @(negedge clk);
        checkOutput("preReset_c2", 4'b1110);
        #2 rst = 1'b1;
        #1 checkOutput("asyncReset", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("resetHeld", 4'b0000);
        @(negedge clk);
        checkOutput("postResetIdle", 4'b0000);

        // Fresh transfer after reset, looped back into a 4-bit detector model
        detShift = 4'b0000;
        applyStimulus(8'h0D, 4'd4, 4'd1, 4'd0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (seq_valid) detShift = {detShift[2:0], seq};
            case (c)
                0, 1, 3: expNib = 4'b1110;
                2:       expNib = 4'b0110;
                default: expNib = 4'b0001;
            endcase
            checkOutput($sformatf("postReset_c%0d", c + 1), expNib);
        end
        checks++;
        if (detShift !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL loopbackDetect: detector saw %b expected 1101", detShift);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
